// File: rtl/servo_pwm_pkg.sv
// -----------------------------------------------------------------------------
// servo_pwm_pkg
// Shared constants and elaboration-time helpers for the servo PWM generator.
// Converts the microsecond-based timing parameters into clock-cycle counts,
// sizes the counters, and provides the centre-position reset value.
// No ports (package).
// -----------------------------------------------------------------------------
package servo_pwm_pkg;

    // Whole clock cycles per microsecond times a duration in microseconds.
    // The per-microsecond rate is floored first so every derived count uses
    // the same integer clock rate.
    function automatic int cyc_from_us(input int clk_hz, input int us);
        return (clk_hz / 1000000) * us;
    endfunction

    // Length of one servo frame in clock cycles.
    function automatic int frame_cyc(input int clk_hz, input int frame_us);
        return cyc_from_us(clk_hz, frame_us);
    endfunction

    // Length of the minimum-pulse phase (position 0) in clock cycles.
    function automatic int min_cyc(input int clk_hz, input int min_us);
        return cyc_from_us(clk_hz, min_us);
    endfunction

    // Clock cycles per position step; floored, so full scale may fall a little
    // short of the nominal maximum pulse width.
    function automatic int tick_cyc(input int clk_hz, input int min_us,
                                    input int max_us, input int res);
        return (cyc_from_us(clk_hz, max_us) - cyc_from_us(clk_hz, min_us)) >> res;
    endfunction

    // Bits needed for a counter running 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Mid-scale position, used as the reset value of every channel.
    function automatic int centre_pos(input int res);
        return 1 << (res - 1);
    endfunction

endpackage

// File: rtl/servo_pwm_timebase.sv
// -----------------------------------------------------------------------------
// servo_pwm_timebase
// Shared frame timebase for all servo channels. Owns the frame counter fc,
// the tick prescaler tc and the tick index pt.
//   clk        in  : clock
//   res        in  : asynchronous active-high reset
//   bnd        out : high while fc == 0, i.e. the cycle whose edge starts a frame
//   min_phase  out : high while fc is inside the minimum-pulse phase
//   pt         out : tick index after the minimum phase, saturating at max
// -----------------------------------------------------------------------------
module servo_pwm_timebase
    import servo_pwm_pkg::*;
#(
    parameter int FRAME_CYC = 1000000,
    parameter int MIN_CYC   = 50000,
    parameter int TICK_CYC  = 195,
    parameter int RES       = 8
) (
    input  logic           clk,
    input  logic           res,
    output logic           bnd,
    output logic           min_phase,
    output logic [RES-1:0] pt
);

    localparam int FCW = cnt_w(FRAME_CYC);
    localparam int TCW = cnt_w(TICK_CYC);

    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAME_CYC - 1);
    localparam logic [FCW-1:0] FC_MIN  = FCW'(MIN_CYC);
    localparam logic [TCW-1:0] TC_LAST = TCW'(TICK_CYC - 1);
    localparam logic [RES-1:0] PT_MAX  = '1;

    logic [FCW-1:0] fc;
    logic [TCW-1:0] tc;

    // Reset leaves fc at 0, so the first edge after reset is a frame boundary.
    assign bnd       = (fc == '0);
    assign min_phase = (fc < FC_MIN);

    // Frame counter wraps every FRAME_CYC cycles. The prescaler and tick index
    // are held at zero during the minimum phase so the variable part of every
    // pulse starts from a clean tick. The tick index saturates instead of
    // wrapping so a full-scale channel cannot see a second pulse late in the
    // frame.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            fc <= '0;
            tc <= '0;
            pt <= '0;
        end else begin
            fc <= (fc == FC_LAST) ? '0 : fc + 1'b1;
            if (min_phase) begin
                tc <= '0;
                pt <= '0;
            end else if (tc == TC_LAST) begin
                tc <= '0;
                if (pt != PT_MAX) begin
                    pt <= pt + 1'b1;
                end
            end else begin
                tc <= tc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// -----------------------------------------------------------------------------
// servo_pwm_gen
// Multi-channel hobby-servo PWM generator. All channels share one frame;
// positions are written into shadow registers and become active only at a
// frame boundary, so a pulse is never cut short or stretched mid-frame.
//   clk            in  : clock
//   res            in  : asynchronous active-high reset
//   pos_i          in  : packed positions, channel k at [k*RES +: RES]
//   pos_we_i       in  : write strobe, captures all of pos_i into the shadow
//   ch_en_i        in  : per-channel enable, sampled at each frame boundary
//   servo_o        out : registered PWM outputs
//   frame_start_o  out : one-cycle pulse at each frame start
//   upd_pending_o  out : a written update has not yet fully reached the outputs
// Optional build macro: SERVO_PWM_RAMP_EN - when defined, active positions move
// toward the shadow by at most RAMP_STEP per frame instead of jumping.
// -----------------------------------------------------------------------------
module servo_pwm_gen
    import servo_pwm_pkg::*;
#(
    parameter int CHANNELS     = 18,
    parameter int RES          = 8,
    parameter int CLK_HZ       = 50000000,
    parameter int FRAME_US     = 20000,
    parameter int PULSE_MIN_US = 1000,
    parameter int PULSE_MAX_US = 2000,
    parameter int RAMP_STEP    = 4
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic [CHANNELS*RES-1:0] pos_i,
    input  logic                    pos_we_i,
    input  logic [CHANNELS-1:0]     ch_en_i,
    output logic [CHANNELS-1:0]     servo_o,
    output logic                    frame_start_o,
    output logic                    upd_pending_o
);

    localparam int FRAME_CYC = frame_cyc(CLK_HZ, FRAME_US);
    localparam int MIN_CYC   = min_cyc(CLK_HZ, PULSE_MIN_US);
    localparam int TICK_CYC  = tick_cyc(CLK_HZ, PULSE_MIN_US, PULSE_MAX_US, RES);

    localparam logic [RES-1:0] CENTRE = RES'(centre_pos(RES));

    // Reject configurations where a position step rounds to zero cycles or a
    // full-scale pulse would not fit inside the frame.
    if (TICK_CYC < 1 || MIN_CYC + (2**RES - 1) * TICK_CYC >= FRAME_CYC) begin : g_bad_timing
        $error("servo_pwm_gen: pulse range does not fit in the frame");
    end
    if (CHANNELS < 1 || CHANNELS > 64 || RAMP_STEP < 1) begin : g_bad_params
        $error("servo_pwm_gen: CHANNELS must be 1..64 and RAMP_STEP at least 1");
    end

    logic [CHANNELS-1:0][RES-1:0] shadow;
    logic [CHANNELS-1:0][RES-1:0] act;
    logic [CHANNELS-1:0][RES-1:0] act_next;
    logic [CHANNELS-1:0][RES-1:0] pos_eff;
    logic [CHANNELS-1:0]          act_en;
    logic [CHANNELS-1:0]          en_eff;
    logic [CHANNELS-1:0]          servo_d;
    logic                         pend;
    logic                         bnd;
    logic                         min_phase;
    logic [RES-1:0]               pt;

    servo_pwm_timebase #(
        .FRAME_CYC (FRAME_CYC),
        .MIN_CYC   (MIN_CYC),
        .TICK_CYC  (TICK_CYC),
        .RES       (RES)
    ) u_timebase (
        .clk       (clk),
        .res       (res),
        .bnd       (bnd),
        .min_phase (min_phase),
        .pt        (pt)
    );

`ifdef SERVO_PWM_RAMP_EN
    localparam int             STEP_LIM = (RAMP_STEP > 2**RES - 1) ? 2**RES - 1 : RAMP_STEP;
    localparam logic [RES-1:0] STEP     = RES'(STEP_LIM);

    // Each channel closes the gap to its shadow by at most STEP per frame and
    // lands exactly on the shadow value once it is within one step.
    always_comb begin
        act_next = act;
        for (int k = 0; k < CHANNELS; k++) begin
            if (shadow[k] > act[k]) begin
                act_next[k] = (shadow[k] - act[k] > STEP) ? act[k] + STEP : shadow[k];
            end else if (shadow[k] < act[k]) begin
                act_next[k] = (act[k] - shadow[k] > STEP) ? act[k] - STEP : shadow[k];
            end
        end
    end
`else
    assign act_next = shadow;
`endif

    // In the boundary cycle the active registers are only just being loaded,
    // so the output decode uses the incoming values. This lets every enabled
    // channel rise in the same cycle as frame_start_o, including the very
    // first frame after reset.
    assign en_eff  = bnd ? ch_en_i  : act_en;
    assign pos_eff = bnd ? act_next : act;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        assign servo_d[k] = en_eff[k] & (min_phase | (pt < pos_eff[k]));
    end

    // Shadow capture and boundary transfer. A write in the boundary cycle
    // still lands in the shadow while the boundary takes the previous shadow,
    // so pending stays set and the new value goes out one frame later.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            shadow <= {CHANNELS{CENTRE}};
            act    <= {CHANNELS{CENTRE}};
            act_en <= '0;
            pend   <= 1'b0;
        end else begin
            if (pos_we_i) begin
                shadow <= pos_i;
            end
            if (bnd) begin
                act    <= act_next;
                act_en <= ch_en_i;
            end
            if (pos_we_i) begin
                pend <= 1'b1;
            end else if (bnd) begin
                pend <= (act_next != shadow);
            end
        end
    end

    // Registered outputs, one cycle behind the timebase state.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            servo_o       <= '0;
            frame_start_o <= 1'b0;
        end else begin
            servo_o       <= servo_d;
            frame_start_o <= bnd;
        end
    end

    assign upd_pending_o = pend;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_gen
// Self-checking bench for servo_pwm_gen with 4 channels, 8-bit positions,
// 1 MHz clock, 3000-cycle frame, 1000-cycle minimum pulse, 3 cycles per step.
// Expected pulse widths are 1000 + position*3 cycles.
// -----------------------------------------------------------------------------
module tb_servo_pwm_gen;

    localparam int CH    = 4;
    localparam int FRAME = 3000;

    logic              clk = 1'b0;
    logic              res;
    logic [CH*8-1:0]   pos_i;
    logic              pos_we_i;
    logic [CH-1:0]     ch_en_i;
    logic [CH-1:0]     servo_o;
    logic              frame_start_o;
    logic              upd_pending_o;

    int testCount = 0;
    int failCount = 0;
    int widths [CH];
    logic [CH*8-1:0] curPos;

`ifdef SERVO_PWM_RAMP_EN
    int rampW [4] = '{1396, 1408, 1420, 1420};
    int rampP [4] = '{1, 1, 0, 0};
`else
    int rampW [4] = '{1420, 1420, 1420, 1420};
    int rampP [4] = '{0, 0, 0, 0};
`endif

    servo_pwm_gen #(
        .CHANNELS     (CH),
        .RES          (8),
        .CLK_HZ       (1000000),
        .FRAME_US     (3000),
        .PULSE_MIN_US (1000),
        .PULSE_MAX_US (2000),
        .RAMP_STEP    (4)
    ) dut (
        .clk           (clk),
        .res           (res),
        .pos_i         (pos_i),
        .pos_we_i      (pos_we_i),
        .ch_en_i       (ch_en_i),
        .servo_o       (servo_o),
        .frame_start_o (frame_start_o),
        .upd_pending_o (upd_pending_o)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [CH*8-1:0] pos, input logic we,
                                 input logic [CH-1:0] en);
        pos_i    = pos;
        pos_we_i = we;
        ch_en_i  = en;
    endtask

    // One-cycle write strobe, driven from a negedge.
    task automatic pulseWrite(input logic [CH*8-1:0] pos, input logic [CH-1:0] en);
        curPos = pos;
        applyStimulus(pos, 1'b1, en);
        @(negedge clk);
        applyStimulus(pos, 1'b0, en);
    endtask

    // Called on the negedge where frame_start_o is high; counts high cycles per
    // channel over one frame and checks the next frame starts exactly FRAME
    // cycles later with no stray start pulse in between.
    task automatic measureFrame();
        int extra;
        extra = 0;
        for (int k = 0; k < CH; k++) widths[k] = 0;
        for (int c = 0; c < FRAME; c++) begin
            for (int k = 0; k < CH; k++) begin
                if (servo_o[k] === 1'b1) widths[k]++;
            end
            if (c != 0 && frame_start_o !== 1'b0) extra++;
            @(negedge clk);
        end
        checkOutput("frame_period", frame_start_o, 1);
        checkOutput("stray_frame_start", extra, 0);
    endtask

    task automatic checkWidths(input string tag, input int e0, input int e1,
                               input int e2, input int e3);
        int exp [CH];
        exp = '{e0, e1, e2, e3};
        for (int k = 0; k < CH; k++) begin
            checkOutput($sformatf("%s_ch%0d", tag, k), widths[k], exp[k]);
        end
    endtask

    // Hard time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        curPos = '0;
        applyStimulus('0, 1'b0, 4'hF);
        res = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_servo",   servo_o,       0);
        checkOutput("reset_fstart",  frame_start_o, 0);
        checkOutput("reset_pending", upd_pending_o, 0);

        // First frame after release: centre positions on all channels.
        res = 1'b0;
        @(negedge clk);
        checkOutput("first_fstart", frame_start_o, 1);
        checkOutput("first_servo",  servo_o,       15);
        measureFrame();
        checkWidths("centre", 1384, 1384, 1384, 1384);
        checkOutput("pend_idle", upd_pending_o, 0);

        // Mid-frame write: current frame unaffected, pending until boundary.
        fork
            measureFrame();
            begin
                repeat (100) @(negedge clk);
                checkOutput("pend_before_wr", upd_pending_o, 0);
                pulseWrite({8'd128, 8'd1, 8'd255, 8'd0}, 4'hF);
                checkOutput("pend_after_wr", upd_pending_o, 1);
                repeat (2898) @(negedge clk);
                checkOutput("pend_last_cycle", upd_pending_o, 1);
            end
        join
        checkWidths("old_during_wr", 1384, 1384, 1384, 1384);
        checkOutput("pend_cleared", upd_pending_o, 0);
        measureFrame();
        checkWidths("new_pos", 1000, 1765, 1003, 1384);

        // Write exactly in the boundary cycle: takes effect one frame later.
        fork
            measureFrame();
            begin
                repeat (2999) @(negedge clk);
                checkOutput("pend_pre_bnd_wr", upd_pending_o, 0);
                curPos = {8'd128, 8'd1, 8'd255, 8'd255};
                applyStimulus(curPos, 1'b1, 4'hF);
            end
        join
        applyStimulus(curPos, 1'b0, 4'hF);
        checkWidths("bnd_wr_same", 1000, 1765, 1003, 1384);
        checkOutput("pend_bnd_wr_set", upd_pending_o, 1);
        fork
            measureFrame();
            begin
                repeat (2999) @(negedge clk);
                checkOutput("pend_bnd_wr_hold", upd_pending_o, 1);
            end
        join
        checkWidths("bnd_wr_old", 1000, 1765, 1003, 1384);
        checkOutput("pend_bnd_wr_clear", upd_pending_o, 0);

        // Disable channel 2 mid-pulse: current pulse completes, next frame off.
        fork
            measureFrame();
            begin
                repeat (200) @(negedge clk);
                applyStimulus(curPos, 1'b0, 4'b1011);
            end
        join
        checkWidths("en_off_cur", 1765, 1765, 1003, 1384);
        fork
            measureFrame();
            begin
                repeat (100) @(negedge clk);
                applyStimulus(curPos, 1'b0, 4'hF);
            end
        join
        checkWidths("en_off_next", 1765, 1765, 0, 1384);

        // Reset at cycle 500: outputs drop at once, restart from centre.
        repeat (500) @(negedge clk);
        checkOutput("pre_reset_servo", servo_o, 15);
        res = 1'b1;
        #1;
        checkOutput("async_reset_servo", servo_o, 0);
        repeat (2) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        checkOutput("restart_fstart", frame_start_o, 1);
        checkOutput("restart_servo",  servo_o,       15);
        fork
            measureFrame();
            begin
                repeat (50) @(negedge clk);
                pulseWrite({8'd140, 8'd140, 8'd140, 8'd140}, 4'hF);
            end
        join
        checkWidths("after_reset", 1384, 1384, 1384, 1384);

        // Step from 128 to 140: ramped or immediate depending on the build.
        for (int f = 0; f < 4; f++) begin
            checkOutput($sformatf("step_pend_f%0d", f), upd_pending_o, rampP[f]);
            measureFrame();
            checkWidths($sformatf("step_f%0d", f), rampW[f], rampW[f], rampW[f], rampW[f]);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Parametrised multi-channel hobby-servo PWM generator: drives `CHANNELS` servo outputs with one common frame period and per-channel pulse widths between a configurable minimum and maximum. Positions arrive as a packed bus and are written into shadow registers. Shadow values become active only at a frame boundary, so no output ever shows a runt or stretched pulse. It sits between the motion/command logic and the servo pins, and is the generalised successor of the fixed 18-channel servo controller.

## Interface
- `CHANNELS`, 18, number of servo outputs (1..64)
- `RES`, 8, position resolution in bits
- `CLK_HZ`, 50000000, clock frequency
- `FRAME_US`, 20000, frame period in µs
- `PULSE_MIN_US`, 1000, pulse width at position 0
- `PULSE_MAX_US`, 2000, nominal pulse width at full scale
- `RAMP_STEP`, 4, max position change per frame (only with the ramp feature)

- `clk` in 1: clock
- `res` in 1: asynchronous, active-high reset
- `pos_i` in CHANNELS*RES: packed positions; channel k at bits [k*RES +: RES]
- `pos_we_i` in 1: write strobe; captures the whole `pos_i` into the shadow registers
- `ch_en_i` in CHANNELS: per-channel enable
- `servo_o` out CHANNELS: PWM outputs (registered)
- `frame_start_o` out 1: one-cycle pulse at each frame start
- `upd_pending_o` out 1: shadow differs from active / update not yet applied

## Operation
- Derived constants, integer arithmetic, floors:
  - FRAME_CYC = CLK_HZ/1e6*FRAME_US
  - MIN_CYC = CLK_HZ/1e6*PULSE_MIN_US
  - TICK_CYC = (MAX_CYC−MIN_CYC) >> RES
- Elaboration error if TICK_CYC < 1 or MIN_CYC + (2^RES−1)*TICK_CYC ≥ FRAME_CYC.
- Frame counter `fc` runs 0..FRAME_CYC−1 and wraps.
- Pulse phase:
  - cycles 0..MIN_CYC−1 are the minimum phase.
  - After that, tick prescaler `tc` counts 0..TICK_CYC−1 and tick index `pt` increments on each wrap.
- Channel k is high while in the minimum phase, or while `pt < act_pos[k]`, and only if `act_en[k]` is set.
- High time for a channel is exactly MIN_CYC + act_pos[k]*TICK_CYC cycles. Position 0 gives exactly MIN_CYC.
- Shadow registers:
  - `pos_we_i` loads shadow ← `pos_i` and sets pending.
  - At the frame boundary (`fc` wraps to 0), active positions ← shadow, `act_en` ← `ch_en_i`, and pending clears.
- Simultaneous write and boundary in the same cycle: the boundary applies the old shadow, the new value is captured, and pending stays set. It applies at the next frame.
- Enable changes never truncate a pulse in progress; they take effect only at the next frame.
- `pt` saturates at 2^RES−1; it does not wrap within a frame.

## Timing
- Reset values:
  - `servo_o` = 0, `frame_start_o` = 0, `upd_pending_o` = 0
  - `fc`, `tc`, `pt` = 0
  - shadow and active positions = 2^(RES−1) (centre)
  - `act_en` = 0
- First frame: the first clock edge after `res` deasserts is a frame boundary.
  - Active registers load at this edge.
  - `frame_start_o` is high in the following cycle.
  - `servo_o` rises in that same cycle for enabled channels.
- Output latency: `servo_o` and `frame_start_o` are registered, one cycle behind the counter state that decodes them. All channels rise in the same cycle as `frame_start_o`.
- `pos_we_i` has a single-cycle effect and no back-pressure; a write is accepted every cycle. `upd_pending_o` rises one cycle after the strobe.
- Reset asserted mid-frame: all outputs drop asynchronously to 0 and the frame restarts from the first-frame rule.

## Configuration
- `SERVO_PWM_RAMP_EN` defined: at each boundary each active position moves toward its shadow by at most `RAMP_STEP`, with no overshoot. Pending clears only when every active position equals its shadow.
- `SERVO_PWM_RAMP_EN` undefined: active positions jump to shadow in one frame. `RAMP_STEP` is ignored.

## Structure
- Package `servo_pwm_pkg` holds:
  - functions deriving FRAME_CYC, MIN_CYC and TICK_CYC from the parameters
  - clog2-based counter widths
  - the centre-position reset constant
- Sub-module `servo_pwm_timebase` owns `fc`, `tc` and `pt`. It outputs the boundary strobe, the minimum-phase flag and the `pt` value.
- The top level holds the shadow/active registers, the ramp logic and the per-channel compare (generate loop).

## Test plan
Bench parameters: CLK_HZ=1000000, FRAME_US=3000, MIN 1000, MAX 2000, RES=8, CHANNELS=4, giving TICK_CYC=3 and FRAME_CYC=3000.
- Reset release with all enables high, no writes: every channel is high for 1384 cycles (1000 + 128*3). `frame_start_o` pulses every 3000 cycles.
- Write positions {0, 255, 1, 128}, then wait for the boundary: next-frame widths are 1000, 1765, 1003 and 1384 cycles. `upd_pending_o` is 1 until that boundary.
- `pos_we_i` in the exact boundary cycle with value 255 on channel 0: that frame uses the old value, the following frame is 1765 cycles wide, and pending stays 1 across one frame.
- Deassert `ch_en_i[2]` 200 cycles into the pulse: the current pulse completes at full width and the next frame has no pulse on channel 2.
- Assert `res` at cycle 500 of a frame: `servo_o` drops to 0 immediately. After release, the first frame's pulses start one cycle after the first edge.
- With `SERVO_PWM_RAMP_EN` and RAMP_STEP=4, step from 128 to 140: per-frame positions are 132, 136, 140, 140. Pending clears after the third boundary.
